// File: rtl/l0_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : l0_loader_if
//  Description : Bus bundle between the L0 loader, the core SRAM read port,
//                the L0 FIFO bank and the controller's start/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface l0_loader_if #(
    parameter int ROW    = 8,
    parameter int BW     = 4,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11
);
    // Controller handshake
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    num_words;
    logic                busy;
    logic                done;
    // SRAM read port
    logic                sram_cen;
    logic                sram_wen;
    logic [ADDR_W-1:0]   sram_addr;
    logic [ROW*BW-1:0]   sram_q;
    // L0 FIFO bank write port
    logic [ROW-1:0]      l0_full;
    logic [ROW-1:0]      l0_wr;
    logic [ROW*BW-1:0]   l0_in;

    // Environment side: controller, SRAM and FIFO bank
    modport master (
        output start, base_addr, num_words, sram_q, l0_full,
        input  busy, done, sram_cen, sram_wen, sram_addr, l0_wr, l0_in
    );

    // Loader side
    modport slave (
        input  start, base_addr, num_words, sram_q, l0_full,
        output busy, done, sram_cen, sram_wen, sram_addr, l0_wr, l0_in
    );
endinterface : l0_loader_if
`default_nettype wire

// File: rtl/l0_loader.sv
`default_nettype none
// ============================================================================
//  Module      : l0_loader
//  Description : Streams a block of SRAM words into the L0 FIFO bank, one word
//                per cycle, throttling on any FIFO full and absorbing the
//                1-cycle SRAM read latency with a single hold register.
//  Revision    : 1.0  initial release
// ============================================================================
module l0_loader #(
    parameter int ROW    = 8,
    parameter int BW     = 4,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11
) (
    input  wire logic     clk,
    input  wire logic     reset,
    l0_loader_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]          state_q,      state_d;
    logic [ADDR_W-1:0]   base_q,       base_d;
    logic [LEN_W-1:0]    num_q,        num_d;
    logic [LEN_W-1:0]    issued_q,     issued_d;
    logic [LEN_W-1:0]    written_q,    written_d;
    logic [ROW*BW-1:0]   hold_q,       hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                inflight_q,   inflight_d;

    logic                w_any_full;
    logic                w_issue;
    logic                w_src_valid;
    logic                w_write;
    logic [ROW*BW-1:0]   w_src;

    // A read may only be launched when the word it returns is guaranteed a
    // landing place: the hold register must be free, and a word already in
    // flight must not be about to occupy it.
    always_comb begin
        w_any_full  = |bus.l0_full;
        w_issue     = (state_q == S_RUN) && (issued_q < num_q) && !hold_valid_q
                      && !(inflight_q && w_any_full);
        w_src_valid = hold_valid_q || inflight_q;
        w_src       = hold_valid_q ? hold_q : bus.sram_q;
        w_write     = w_src_valid && !w_any_full;
    end

    // Outputs: SRAM strobes and FIFO writes are combinational so a full flag
    // blocks the write in the very cycle it rises.
    always_comb begin
        bus.busy      = (state_q == S_RUN) || (state_q == S_FIN);
        bus.done      = (state_q == S_FIN);
        bus.sram_cen  = !w_issue;
        bus.sram_wen  = 1'b1;
        bus.sram_addr = w_issue ? (base_q + ADDR_W'(issued_q)) : '0;
        bus.l0_wr     = {ROW{w_write}};
        bus.l0_in     = w_write ? w_src : '0;
    end

    // Next-state: job capture, issue/write counting, stall capture into hold.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        issued_d     = issued_q;
        written_d    = written_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        inflight_d   = w_issue;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d    = bus.base_addr;
                    num_d     = bus.num_words;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = (bus.num_words != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (w_write) begin
                    written_d    = written_q + LEN_W'(1);
                    hold_valid_d = 1'b0;
                    if ((written_q + LEN_W'(1)) == num_q) begin
                        state_d = S_FIN;
                    end
                end
                // Word returning from SRAM while the bank is full is parked.
                if (inflight_q && w_any_full) begin
                    hold_d       = bus.sram_q;
                    hold_valid_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any pending or held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            num_q        <= '0;
            issued_q     <= '0;
            written_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            issued_q     <= issued_d;
            written_q    <= written_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            inflight_q   <= inflight_d;
        end
    end

endmodule : l0_loader
`default_nettype wire

// File: tb/tb_l0_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l0_loader
//  Description : Scoreboard bench for l0_loader: expected SRAM addresses and
//                FIFO words are queued by the stimulus thread and popped by a
//                monitor whenever the DUT reads or writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l0_loader;

    localparam int ROW    = 8;
    localparam int BW     = 4;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 11;

    logic clk;
    logic reset;

    l0_loader_if #(.ROW(ROW), .BW(BW), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    l0_loader #(.ROW(ROW), .BW(BW), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:2047];
    logic [31:0] exp_data[$];
    logic [10:0] exp_addr[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int first_wr_cyc = 0;
    int last_wr_cyc = 0;
    bit first_pending = 0;
    bit zero_job = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (!bus.sram_cen) bus.sram_q <= mem[bus.sram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: checks every read, write and done pulse against the queues
    always @(negedge clk) begin
        if (!bus.sram_cen) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_read", 32'(bus.sram_addr), 32'hFFFF_FFFF);
            end else begin
                chk("read_addr", 32'(bus.sram_addr), 32'(exp_addr.pop_front()));
            end
        end
        if (bus.l0_wr != '0) begin
            chk("wr_strobe", 32'(bus.l0_wr), 32'h0000_00FF);
            chk("wr_while_full", 32'(bus.l0_full), 32'h0);
            if (exp_data.size() == 0) begin
                chk("unexpected_write", bus.l0_in, 32'hDEAD_DEAD);
            end else begin
                chk("wr_data", bus.l0_in, exp_data.pop_front());
            end
            if (first_pending) begin
                chk("first_wr_latency", 32'(cyc - start_cyc), 32'd2);
                first_pending = 0;
                first_wr_cyc  = cyc;
            end
            last_wr_cyc = cyc;
            wr_cnt++;
        end
        if (bus.done) begin
            done_cnt++;
            chk("done_busy", 32'(bus.busy), 32'd1);
            if (zero_job) chk("done_timing_zero", 32'(cyc), 32'(start_cyc + 1));
            else          chk("done_timing", 32'(cyc), 32'(last_wr_cyc + 1));
        end
    end

    task automatic next_tick;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [10:0] b, input logic [10:0] n);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.num_words = n;
        start_cyc     = cyc;
        first_pending = (n != 0);
        zero_job      = (n == 0);
        next_tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got=%0d done pulses want=%0d", done_cnt, target);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_cen"},  32'(bus.sram_cen), 32'd1);
        chk({tag, "_wen"},  32'(bus.sram_wen), 32'd1);
        chk({tag, "_addr"}, 32'(bus.sram_addr), 32'd0);
        chk({tag, "_wr"},   32'(bus.l0_wr), 32'd0);
        chk({tag, "_in"},   bus.l0_in, 32'd0);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
        chk({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
        chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        next_tick();
    endtask

    initial begin
        int done_exp;
        int w0;
        bit hit;
        for (int a = 0; a < 2048; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
        mem[11'h010] = 32'h1111_1111; mem[11'h011] = 32'h2222_2222;
        mem[11'h012] = 32'h3333_3333; mem[11'h013] = 32'h4444_4444;
        mem[11'h014] = 32'h5555_5555; mem[11'h015] = 32'h6666_6666;
        mem[11'h016] = 32'h7777_7777; mem[11'h017] = 32'h8888_8888;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.l0_full = '0;
        done_exp = 0;
        repeat (3) next_tick();
        @(negedge clk);
        check_idle("reset");
        next_tick();
        reset = 1'b0;
        next_tick();

        // Basic stream
        exp_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                     32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
        exp_addr = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h014, 11'h015, 11'h016, 11'h017};
        kick(11'h010, 11'd8);
        done_exp++;
        wait_done(done_exp);
        chk("basic_wr_span", 32'(last_wr_cyc - first_wr_cyc), 32'd7);
        after_done("basic");

        // Backpressure: FIFO 3 full for 5 cycles after the 2nd write
        exp_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                     32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
        exp_addr = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h014, 11'h015, 11'h016, 11'h017};
        w0 = wr_cnt;
        kick(11'h010, 11'd8);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_cnt == w0 + 2) begin hit = 1; break; end
        end
        chk("bp_reached_2_writes", 32'(hit), 32'd1);
        next_tick();
        bus.l0_full = 8'h08;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stall_wr", 32'(bus.l0_wr), 32'd0);
            chk("bp_stall_cen", 32'(bus.sram_cen), 32'd1);
            next_tick();
        end
        bus.l0_full = '0;
        done_exp++;
        wait_done(done_exp);
        chk("bp_word_count", 32'(wr_cnt - w0), 32'd8);
        after_done("bp");

        // Zero length
        w0 = wr_cnt;
        kick(11'h055, 11'd0);
        done_exp++;
        wait_done(done_exp);
        chk("zero_no_write", 32'(wr_cnt - w0), 32'd0);
        after_done("zero");
        zero_job = 0;

        // Wrap-around
        exp_data = '{32'hC0DE_07FE, 32'hC0DE_07FF, 32'hC0DE_0000, 32'hC0DE_0001};
        exp_addr = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        kick(11'h7FE, 11'd4);
        done_exp++;
        wait_done(done_exp);
        after_done("wrap");

        // Reset mid-run after 3 writes
        exp_data = '{32'hC0DE_0020, 32'hC0DE_0021, 32'hC0DE_0022, 32'hC0DE_0023,
                     32'hC0DE_0024, 32'hC0DE_0025, 32'hC0DE_0026, 32'hC0DE_0027};
        exp_addr = '{11'h020, 11'h021, 11'h022, 11'h023, 11'h024, 11'h025, 11'h026, 11'h027};
        w0 = wr_cnt;
        kick(11'h020, 11'd8);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_cnt == w0 + 3) begin hit = 1; break; end
        end
        chk("rst_reached_3_writes", 32'(hit), 32'd1);
        next_tick();
        reset = 1'b1;
        next_tick();
        @(negedge clk);
        check_idle("midrst");
        exp_data.delete();
        exp_addr.delete();
        first_pending = 0;
        next_tick();
        reset = 1'b0;
        repeat (2) next_tick();
        chk("midrst_no_done", 32'(done_cnt), 32'(done_exp));
        exp_data = '{32'hC0DE_0020, 32'hC0DE_0021};
        exp_addr = '{11'h020, 11'h021};
        kick(11'h020, 11'd2);
        done_exp++;
        wait_done(done_exp);
        after_done("postrst");

        // Spurious start while busy
        exp_data = '{32'hC0DE_0040, 32'hC0DE_0041, 32'hC0DE_0042, 32'hC0DE_0043, 32'hC0DE_0044};
        exp_addr = '{11'h040, 11'h041, 11'h042, 11'h043, 11'h044};
        w0 = wr_cnt;
        kick(11'h040, 11'd5);
        next_tick();
        bus.start     = 1'b1;
        bus.base_addr = 11'h100;
        bus.num_words = 11'd2;
        next_tick();
        bus.start     = 1'b0;
        done_exp++;
        wait_done(done_exp);
        chk("spur_word_count", 32'(wr_cnt - w0), 32'd5);
        after_done("spur");
        repeat (4) next_tick();
        chk("spur_no_extra_done", 32'(done_cnt), 32'(done_exp));
        @(negedge clk);
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_l0_loader
`default_nettype wire
